// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
//   - md_op_e      : 3-bit MD operation encoding driven by the EX stage
//   - *_CYCLES_DEF : default busy latencies for multiply and divide
//   - md_result_t  : 64-bit {hi, lo} result container
//   - md_is_long   : true for ops that occupy the unit for several cycles
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSV6  = 3'd6,
        MD_RSV7  = 3'd7
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef logic [63:0] md_result_t;

    // Multiply and divide run through the busy counter; moves and reserved ops do not.
    function automatic logic md_is_long(input md_op_e op);
        logic long_op;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: long_op = 1'b1;
            default:                            long_op = 1'b0;
        endcase
        return long_op;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: down-counter that models the fixed latency of the MD unit.
//   clk, reset  : clock, synchronous active-high reset
//   load        : load load_value this cycle (takes priority over decrement)
//   load_value  : number of busy cycles for the accepted operation
//   busy        : counter is nonzero
//   last_cycle  : counter is 1, i.e. the next edge is the commit edge
module md_busy_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             busy,
    output logic             last_cycle
);

    logic [CNT_W-1:0] count_r;

    // Count register: load on accept, otherwise count down to zero and hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign busy       = (count_r != {CNT_W{1'b0}});
    assign last_cycle = (count_r == CNT_W'(1));

endmodule

// File: rtl/md_scheduler.sv
// md_scheduler: multiply/divide sequencer for the 5-stage MIPS pipeline; owns HI/LO.
//   clk, reset  : clock, synchronous active-high reset
//   start, op   : EX-stage MD operation and its encoding (md_op_e)
//   a, b        : forwarded rs / rt operands
//   id_md_use   : instruction in ID touches the MD unit (MD op or mfhi/mflo)
//   hi, lo      : architectural HI/LO registers
//   busy        : multi-cycle operation in flight
//   stall_md    : stall request to the hazard unit
// The result is computed at the accept edge and parked in pending registers;
// it is copied into HI/LO on the edge where the busy counter goes 1 -> 0.
module md_scheduler
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        id_md_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [31:0]        hi_r;
    logic [31:0]        lo_r;
    logic [31:0]        pend_hi_r;
    logic [31:0]        pend_lo_r;

    md_op_e             op_s;
    logic               busy_s;
    logic               last_cycle_s;
    logic               accept_s;
    logic               load_s;
    logic [CNT_W-1:0]   load_value_s;

    logic signed [63:0] smul_s;
    logic [63:0]        umul_s;
    logic               div_by_zero_s;
    logic [31:0]        udivisor_s;
    logic [31:0]        uq_s;
    logic [31:0]        ur_s;
    logic [31:0]        mag_a_s;
    logic [31:0]        mag_b_s;
    logic [31:0]        sq_mag_s;
    logic [31:0]        sr_mag_s;
    logic [31:0]        sq_s;
    logic [31:0]        sr_s;
    md_result_t         result_s;

    // Operation decode, accept qualification and counter load value.
    always_comb begin
        op_s     = md_op_e'(op);
        // A start on the commit edge still sees busy=1 and is dropped.
        accept_s = start & ~busy_s;
        load_s   = accept_s & md_is_long(op_s);
        case (op_s)
            MD_MULT, MD_MULTU: load_value_s = CNT_W'(MULT_CYCLES);
            MD_DIV, MD_DIVU:   load_value_s = CNT_W'(DIV_CYCLES);
            default:           load_value_s = {CNT_W{1'b0}};
        endcase
    end

    // Arithmetic datapath: products, quotients and remainders from a and b.
    always_comb begin
        smul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        umul_s = {32'd0, a} * {32'd0, b};

        // Divisor forced to 1 on divide-by-zero; that result is discarded anyway.
        div_by_zero_s = (b == 32'd0);
        udivisor_s    = div_by_zero_s ? 32'd1 : b;
        uq_s          = a / udivisor_s;
        ur_s          = a % udivisor_s;

        // Signed divide via magnitudes. 0x80000000 / -1 falls out as
        // quotient 0x80000000, remainder 0 with no special case.
        mag_a_s  = a[31] ? (32'd0 - a) : a;
        mag_b_s  = b[31] ? (32'd0 - b) : b;
        sq_mag_s = mag_a_s / (div_by_zero_s ? 32'd1 : mag_b_s);
        sr_mag_s = mag_a_s % (div_by_zero_s ? 32'd1 : mag_b_s);
        sq_s     = (a[31] ^ b[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
        sr_s     = a[31] ? (32'd0 - sr_mag_s) : sr_mag_s;

        // Divide-by-zero re-commits the current HI/LO, leaving them unchanged.
        case (op_s)
            MD_MULT:  result_s = md_result_t'(smul_s);
            MD_MULTU: result_s = umul_s;
            MD_DIV:   result_s = div_by_zero_s ? {hi_r, lo_r} : {sr_s, sq_s};
            MD_DIVU:  result_s = div_by_zero_s ? {hi_r, lo_r} : {ur_s, uq_s};
            default:  result_s = {hi_r, lo_r};
        endcase
    end

    md_busy_counter #(
        .CNT_W (CNT_W)
    ) u_busy_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_value (load_value_s),
        .busy       (busy_s),
        .last_cycle (last_cycle_s)
    );

    // Pending result capture on accepting a multiply or divide.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
        end else if (load_s) begin
            pend_hi_r <= result_s[63:32];
            pend_lo_r <= result_s[31:0];
        end else begin
            pend_hi_r <= pend_hi_r;
            pend_lo_r <= pend_lo_r;
        end
    end

    // HI register: direct move, or commit of the pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= 32'd0;
        end else if (accept_s && (op_s == MD_MTHI)) begin
            hi_r <= a;
        end else if (last_cycle_s) begin
            hi_r <= pend_hi_r;
        end else begin
            hi_r <= hi_r;
        end
    end

    // LO register: direct move, or commit of the pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_r <= 32'd0;
        end else if (accept_s && (op_s == MD_MTLO)) begin
            lo_r <= a;
        end else if (last_cycle_s) begin
            lo_r <= pend_lo_r;
        end else begin
            lo_r <= lo_r;
        end
    end

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_s;
    // Start is included so the instruction behind an MD op stalls in the issue cycle.
    assign stall_md = id_md_use & (start | busy_s);

endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed scoreboard bench for md_scheduler.
// Stimulus pushes the expected {hi, lo, busy length} of each multi-cycle op;
// the monitor pops on every falling edge of busy and compares.
module tb_md_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        id_md_use = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_md;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic busy_prev = 1'b0;
    logic rst_at_edge = 1'b1;
    int   run_len = 0;

    md_scheduler #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .id_md_use (id_md_use),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_md  (stall_md)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_at_edge <= reset;

    task automatic chk(input logic [31:0] act, input logic [31:0] expv, input string name);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: count busy cycles, compare on each busy 1->0 not caused by reset.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            run_len++;
        end
        if (busy_prev && !busy) begin
            if (rst_at_edge) begin
                run_len = 0;
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got hi=0x%08h lo=0x%08h expected no completion", hi, lo);
                run_len = 0;
            end else begin
                e = exp_q.pop_front();
                chk(hi, e.hi, "commit_hi");
                chk(lo, e.lo, "commit_lo");
                chk(32'(run_len), 32'(e.len), "busy_len");
                run_len = 0;
            end
        end
        busy_prev = busy;
    end

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Issue one op for one edge; len > 0 pushes an expected completion.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input int len);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (len > 0) begin
            e.hi = eh;
            e.lo = el;
            e.len = len;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        wait_idle();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk(hi, 32'd0, "reset_hi");
        chk(lo, 32'd0, "reset_lo");
        chk({31'd0, busy}, 32'd0, "reset_busy");
        chk({31'd0, stall_md}, 32'd0, "reset_stall");

        // Multiply / divide results (hand computed).
        issue(3'd0, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 5);
        issue(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);

        // Reserved op: nothing changes, busy stays low.
        issue(3'd6, 32'h1234, 32'h5678, 32'd0, 32'd0, 0);
        chk(hi, 32'hFFFFFFFE, "rsv_hi");
        chk(lo, 32'h00000001, "rsv_lo");

        // Moves, then divide by zero keeps HI/LO.
        issue(3'd4, 32'h11, 32'd0, 32'd0, 32'd0, 0);
        chk(hi, 32'h11, "mthi_hi");
        issue(3'd5, 32'h22, 32'd0, 32'd0, 32'd0, 0);
        chk(lo, 32'h22, "mtlo_lo");
        issue(3'd2, 32'h12345678, 32'd0, 32'h11, 32'h22, 10);

        // Stall while busy; second start in busy cycle 2 must be ignored.
        @(negedge clk);
        id_md_use = 1'b1;
        start = 1'b1;
        op = 3'd0;
        a = 32'h00010000;
        b = 32'h00030000;
        begin
            exp_t e;
            e.hi = 32'd3;
            e.lo = 32'd0;
            e.len = 5;
            exp_q.push_back(e);
        end
        #1;
        chk({31'd0, stall_md}, 32'd1, "stall_start");
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = (i == 2);
            if (i == 2) begin
                op = 3'd3;
                a = 32'd100;
                b = 32'd7;
            end
            #1;
            chk({31'd0, stall_md}, 32'd1, "stall_busy");
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({31'd0, stall_md}, 32'd0, "stall_after");
        chk({31'd0, busy}, 32'd0, "busy_after_stall");
        id_md_use = 1'b0;
        wait_idle();

        // Back-to-back mthi / mtlo.
        @(negedge clk);
        start = 1'b1;
        op = 3'd4;
        a = 32'hCAFE;
        @(negedge clk);
        op = 3'd5;
        a = 32'hBEEF;
        #1;
        chk(hi, 32'hCAFE, "b2b_hi");
        chk(lo, 32'd0, "b2b_lo_before");
        chk({31'd0, busy}, 32'd0, "b2b_busy1");
        @(negedge clk);
        start = 1'b0;
        #1;
        chk(hi, 32'hCAFE, "b2b_hi_hold");
        chk(lo, 32'hBEEF, "b2b_lo");
        chk({31'd0, busy}, 32'd0, "b2b_busy2");

        // Reset in busy cycle 3 aborts the multiply.
        @(negedge clk);
        start = 1'b1;
        op = 3'd1;
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk({31'd0, busy}, 32'd0, "abort_busy");
        chk(hi, 32'd0, "abort_hi");
        chk(lo, 32'd0, "abort_lo");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk(hi, 32'd0, "abort_hi_late");
        chk(lo, 32'd0, "abort_lo_late");
        chk({31'd0, busy}, 32'd0, "abort_busy_late");

        chk(32'(exp_q.size()), 32'd0, "queue_drain");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Multiply/divide sequencer for the 5-stage MIPS pipeline; owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the EX stage.
- Models fixed multi-cycle latency with a busy counter.
- Drives the stall request that freezes IF/ID and bubbles ID/EX while an instruction in ID needs the busy unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  EX-stage instruction is an MD op this cycle
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved
- a  input  32  rs operand (forwarded value)
- b  input  32  rt operand (forwarded value)
- id_md_use  input  1  ID-stage instruction is an MD op or mfhi/mflo
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  multi-cycle operation in flight
- stall_md  output  1  stall request to the hazard unit

Behaviour:
- Interface: clock clk; reset is synchronous, active-high.
- Reset: hi=0, lo=0, counter=0, busy=0, pending results=0. Reset mid-operation aborts the op; HI/LO still read 0 afterwards.
- Accepted start: start=1 with busy=0 at edge T.
  - mult/multu/div/divu:
    - Compute result from a, b at edge T; latch into pending_hi/pending_lo.
    - Load counter with MULT_CYCLES or DIV_CYCLES.
  - mthi: hi<=a at edge T; counter untouched, busy stays 0.
  - mtlo: lo<=a at edge T; counter untouched, busy stays 0.
  - Reserved op: no effect.
- Counter and commit:
  - busy = (counter != 0).
  - counter decrements once per cycle while nonzero.
  - On the edge where counter goes 1->0, hi<=pending_hi and lo<=pending_lo.
  - Net timing: busy is high for exactly N cycles after T; new HI/LO are visible in the first cycle with busy=0.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0]. multu: unsigned, same split.
  - div: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - divu: unsigned quotient in lo, unsigned remainder in hi.
  - Divide by zero: full DIV_CYCLES busy; pending = current hi/lo, so HI/LO are unchanged.
  - Signed 0x80000000 / -1: lo=0x80000000, hi=0.
- Busy collisions:
  - start while busy=1: ignored; state unchanged. The pipeline must never do this; the bench asserts it never occurs in system tests.
  - start on the commit edge (counter==1) counts as start while busy, so it is ignored.
- stall_md = id_md_use & (start | busy). This is combinational from registered busy plus inputs.
- The hazard unit ORs stall_md into its stall: IF_ID_En=0, ID_EX loads a bubble.
- hi/lo are register outputs with no combinational bypass; mfhi/mflo are held by stall_md.

Decomposition:
- Package md_pkg:
  - op encodings MD_MULT..MD_MTLO
  - defaults MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=10
  - 64-bit result typedef
- Sub-module md_busy_counter:
  - load, load_value, busy, last_cycle
  - width $clog2(max(MULT_CYCLES, DIV_CYCLES)+1)
- Arithmetic stays in md_scheduler.

Test Plan:
- reset, then mult a=0xFFFFFFFD b=4 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF4.
- divu a=7 b=2 -> busy 10 cycles; lo=3, hi=1. Then div a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div a=0x12345678 b=0 with hi=0x11, lo=0x22 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- mult issued, id_md_use=1 during busy -> stall_md=1 in the start cycle and all 5 busy cycles, 0 afterwards. Second start pulse while busy -> ignored, results from the first op only.
- mthi a=0xCAFE then mtlo a=0xBEEF on consecutive cycles -> hi=0xCAFE, lo=0xBEEF one edge each, busy never asserted.
- multu a=0xFFFFFFFF b=0xFFFFFFFF, reset asserted in busy cycle 3 -> next cycle busy=0, hi=0, lo=0; no late commit.
